// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO and sticky
// framing/overrun flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rx_pop,
    input  logic                          clr_err,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam logic [CNTW-1:0] BIT_END  = CNTW'(CLKS_PER_BIT - 1);
    // Counter is cleared on the IDLE->START edge, so the half-bit limit is one
    // less than N/2-1 to land the start sample exactly N/2 cycles after t0.
    localparam logic [CNTW-1:0] HALF_END = CNTW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0]   FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state, state_n;
    logic            rx_meta, rxs;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      sh, sh_n;
    logic            push_n, ferr_n;
    logic            push_q, ferr_q;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push, do_pop, drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            push_q  <= push_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        push_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                    bit_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    sh_n  = {rxs, sh[7:1]};
                    bit_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rxs) begin
                        push_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rxs)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The shift register is stable for at least a bit time after the stop
    // sample, so the delayed push can write it directly.
    always_comb begin
        do_pop  = rx_pop && (count != '0);
        do_push = push_q && ((count != FULL) || do_pop);
        drop    = push_q && !do_push;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            frame_err <= ferr_q | (frame_err & ~clr_err);
            overrun   <= drop   | (overrun   & ~clr_err);
        end
    end

    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo with a queue-based byte model.
module tb_uart_rx_fifo;
    localparam int N = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset, rx, rx_pop, clr_err;
    logic       rx_valid, frame_err, overrun, busy;
    logic [7:0] rx_data;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       m_ferr, m_ovr;

    uart_rx_fifo #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_pop(rx_pop), .clr_err(clr_err),
        .rx_valid(rx_valid), .rx_data(rx_data), .fifo_count(fifo_count),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of a completed frame; popped_same_cycle means rx_pop was held on the push edge.
    task automatic model_frame(input logic [7:0] b, input logic stop, input bit popped_same_cycle);
        if (!stop) begin
            m_ferr = 1'b1;
        end else begin
            if (popped_same_cycle && q.size() > 0)
                void'(q.pop_front());
            if (q.size() < D) q.push_back(b);
            else              m_ovr = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            check({tag, "_data"}, 32'(rx_data), 32'(q[0]));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_ovr"},  32'(overrun),   32'(m_ovr));
    endtask

    task automatic pop_one(input string tag);
        if (q.size() != 0)
            check({tag, "_head"}, 32'(rx_data), 32'(q[0]));
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        if (q.size() != 0)
            void'(q.pop_front());
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drives one 8N1 frame; ticks are counted from the start-bit drive.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_tick,
                              output int valid_tick, output int busy_tick);
        logic [9:0] bits;
        bit         v0;
        int         k;
        bits       = {stop, b, 1'b0};
        valid_tick = 0;
        busy_tick  = 0;
        v0         = rx_valid;
        k          = 0;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int j = 0; j < N; j++) begin
                rx_pop = (pop_tick != 0) && (k + 1 == pop_tick);
                tick();
                k++;
                rx_pop = 1'b0;
                if (busy && busy_tick == 0) busy_tick = k;
                if (!v0 && rx_valid && valid_tick == 0) valid_tick = k;
            end
        end
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int vt, bt;
        send_frame(b, 1'b1, 0, vt, bt);
        model_frame(b, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(rx_valid),   32'd0);
        check({tag, "_data"},  32'(rx_data),    32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_ferr"},  32'(frame_err),  32'd0);
        check({tag, "_ovr"},   32'(overrun),    32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    initial begin
        int vt, bt;
        logic [7:0] rb;
        int npop;

        reset = 1'b1; rx = 1'b1; rx_pop = 1'b0; clr_err = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_values("reset");

        // Single byte: rxs falls 2 ticks after the drive, so rx_valid rises at tick 2+153.
        send_frame(8'hA5, 1'b1, 0, vt, bt);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("single_valid_tick", 32'(vt), 32'd155);
        check("single_busy_tick",  32'(bt), 32'd3);
        check_state("single");
        pop_one("single_pop");
        check_state("single_after_pop");
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        check_state("empty_pop");

        // Glitch shorter than half a bit.
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (20) tick();
        check("glitch_busy", 32'(busy), 32'd0);
        check_state("glitch");

        // Overrun: five back-to-back frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send(8'(i));
        check_state("overrun");
        for (int i = 0; i < 4; i++) pop_one("overrun_pop");
        check_state("overrun_drained");
        pulse_clr();
        check_state("overrun_clr");

        // Full FIFO with a pop on the push edge of the fifth byte.
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        check_state("full_pre");
        send_frame(8'h14, 1'b1, 155, vt, bt);
        model_frame(8'h14, 1'b1, 1'b1);
        check_state("full_pop");
        for (int i = 0; i < 4; i++) pop_one("full_pop_drain");
        check_state("full_drained");

        // Framing error, then a long break followed by a good byte.
        send_frame(8'h3C, 1'b0, 0, vt, bt);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (N) tick();
        check_state("frame_err");
        pulse_clr();
        check_state("frame_err_clr");
        rx = 1'b0;
        repeat (30 * N) tick();
        m_ferr = 1'b1;
        rx = 1'b1;
        repeat (N) tick();
        send(8'h7E);
        check_state("break_then_byte");
        pop_one("break_pop");
        check_state("break_drained");
        pulse_clr();

        // Randomized bytes with random drains between frames.
        for (int it = 0; it < 10; it++) begin
            rb = 8'($urandom);
            send(rb);
            check_state("rand_frame");
            npop = int'($urandom_range(0, 2));
            for (int p = 0; p < npop; p++) pop_one("rand_pop");
        end
        while (q.size() != 0) pop_one("rand_drain");
        pulse_clr();
        check_state("rand_end");

        // Reset mid-frame with two bytes queued.
        send(8'h55);
        send(8'hAA);
        check_state("mid_pre");
        rx = 1'b0;
        repeat (N) tick();
        for (int i = 0; i < 4; i++) begin
            rx = logic'(i[0]);
            repeat (N) tick();
        end
        reset = 1'b1;
        rx    = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_reset_values("mid_reset");
        repeat (2 * N) tick();
        send(8'h99);
        check_state("after_reset");
        pop_one("after_reset_pop");
        check_state("after_reset_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
